// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction timer and its automated responder.
package reaction_pkg;

    localparam int unsigned DelayWDefault      = 14;
    localparam int unsigned PressCyclesDefault = 2;

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StStartPress = 3'd1,
        StWaitLed    = 3'd2,
        StDelay      = 3'd3,
        StRespPress  = 3'd4,
        StFinish     = 3'd5
    } rr_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an asynchronous level plus a registered
// rising-edge pulse taken from the synchronised level.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_dly_q;
    logic                   rise_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q      <= '0;
            level_dly_q <= 1'b0;
            rise_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], d_i};
            level_dly_q <= sync_q[SYNC_STAGES-1];
            rise_q      <= sync_q[SYNC_STAGES-1] & ~level_dly_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/reaction_responder.sv
// Automated reaction-timer player: issues the start press, waits for led, then
// presses user_btn a programmed number of cycles later and reports the latency.
module reaction_responder
    import reaction_pkg::*;
#(
    parameter int unsigned DELAY_W      = DelayWDefault,
    parameter int unsigned PRESS_CYCLES = PressCyclesDefault,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned TIMEOUT      = 16383
) (
    input  logic               clk_i,
    input  logic               areset_ni,
    input  logic               en_i,
    input  logic               start_i,
    input  logic               early_i,
    input  logic [DELAY_W-1:0] delay_cfg_i,
    input  logic               led_i,
    output logic               user_btn_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic [DELAY_W-1:0] resp_cnt_o,
    output logic [2:0]         state_o
);

    localparam logic [DELAY_W-1:0] PressLast   = DELAY_W'(PRESS_CYCLES - 1);
    localparam logic [DELAY_W-1:0] TimeoutLast = DELAY_W'(TIMEOUT - 1);
    localparam logic [DELAY_W-1:0] CntMax      = '1;
    localparam logic [DELAY_W-1:0] One         = DELAY_W'(1);

    rr_state_e          state_q;
    logic [DELAY_W-1:0] cnt_q;
    logic [DELAY_W-1:0] delay_q;
    logic [DELAY_W-1:0] resp_cnt_q;
    logic               early_q;
    logic               user_btn_q;
    logic               done_q;
    logic               timeout_q;
    logic               led_rise;
    logic [DELAY_W-1:0] cnt_inc;
    logic [DELAY_W-1:0] resp_lat;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_led_sync (
        .clk_i  (clk_i),
        .rst_ni (areset_ni),
        .d_i    (led_i),
        .rise_o (led_rise)
    );

    // Saturating increments: counters stick at all-ones rather than wrap.
    assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + One;
    assign resp_lat = (delay_q == CntMax) ? delay_q : delay_q + One;

    always_ff @(posedge clk_i or negedge areset_ni) begin
        if (!areset_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            delay_q    <= '0;
            resp_cnt_q <= '0;
            early_q    <= 1'b0;
            user_btn_q <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            if (!en_i) begin
                state_q    <= StIdle;
                user_btn_q <= 1'b0;
                cnt_q      <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            delay_q    <= delay_cfg_i;
                            early_q    <= early_i;
                            resp_cnt_q <= '0;
                            cnt_q      <= '0;
                            user_btn_q <= 1'b1;
                            state_q    <= StStartPress;
                        end
                    end
                    StStartPress: begin
                        if (cnt_q == PressLast) begin
                            user_btn_q <= 1'b0;
                            cnt_q      <= '0;
                            state_q    <= StWaitLed;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    StWaitLed: begin
                        if (early_q) begin
                            // False start: led is ignored, press after the delay.
                            if (cnt_q == delay_q) begin
                                resp_cnt_q <= '0;
                                user_btn_q <= 1'b1;
                                cnt_q      <= '0;
                                state_q    <= StRespPress;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end else if (led_rise) begin
                            cnt_q <= '0;
                            if (delay_q == '0) begin
                                resp_cnt_q <= resp_lat;
                                user_btn_q <= 1'b1;
                                state_q    <= StRespPress;
                            end else begin
                                state_q <= StDelay;
                            end
                        end else if (cnt_q == TimeoutLast) begin
                            timeout_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= StIdle;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    StDelay: begin
                        if (cnt_q == delay_q - One) begin
                            resp_cnt_q <= resp_lat;
                            user_btn_q <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= StRespPress;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    StRespPress: begin
                        if (cnt_q == PressLast) begin
                            user_btn_q <= 1'b0;
                            done_q     <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= StFinish;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    StFinish: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        user_btn_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= StIdle;
                    end
                endcase
            end
        end
    end

    assign user_btn_o = user_btn_q;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;
    assign timeout_o  = timeout_q;
    assign resp_cnt_o = resp_cnt_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_reaction_responder.sv
// Randomised and directed bench for reaction_responder, checked every cycle
// against a trial-schedule model derived from edge timestamps.
module tb_reaction_responder;

    localparam int unsigned DW = 14;
    localparam int unsigned PC = 2;
    localparam int unsigned SS = 2;
    localparam int unsigned TO = 100;
    localparam int MaxCyc = 60000;
    localparam int RespMax = (1 << DW) - 1;

    localparam int WBtnHi  = 0;
    localparam int WBtnLo  = 1;
    localparam int WDone   = 2;
    localparam int WTo     = 3;
    localparam int WDelay  = 4;
    localparam int WResp   = 5;
    localparam int WIdle   = 6;

    logic          clk       = 1'b0;
    logic          areset_n  = 1'b0;
    logic          en        = 1'b0;
    logic          start     = 1'b0;
    logic          early     = 1'b0;
    logic          led       = 1'b0;
    logic [DW-1:0] delay_cfg = '0;
    logic          user_btn;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [DW-1:0] resp_cnt;
    logic [2:0]    state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: one trial at a time, described by the edge numbers of its phases.
    bit led_hist [0:MaxCyc-1];
    bit m_active = 1'b0;
    bit m_early  = 1'b0;
    bit m_to     = 1'b0;
    int m_t0     = 0;
    int m_w      = 0;
    int m_p      = -1;
    int m_rise   = -1;
    int m_delay  = 0;
    int m_resp   = 0;

    reaction_responder #(
        .DELAY_W      (DW),
        .PRESS_CYCLES (PC),
        .SYNC_STAGES  (SS),
        .TIMEOUT      (TO)
    ) dut (
        .clk_i       (clk),
        .areset_ni   (areset_n),
        .en_i        (en),
        .start_i     (start),
        .early_i     (early),
        .delay_cfg_i (delay_cfg),
        .led_i       (led),
        .user_btn_o  (user_btn),
        .busy_o      (busy),
        .done_o      (done),
        .timeout_o   (timeout),
        .resp_cnt_o  (resp_cnt),
        .state_o     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int n);
        if (n < MaxCyc) led_hist[n] = areset_n ? led : 1'b0;
        m_to = 1'b0;
        if (!areset_n) begin
            m_active = 1'b0;
            m_resp   = 0;
            // Reset empties the synchroniser: forget the recent led samples.
            for (int k = 0; k <= int'(SS) + 1; k++) begin
                if (n - k >= 0 && n - k < MaxCyc) led_hist[n-k] = 1'b0;
            end
        end else if (m_active && !en) begin
            m_active = 1'b0;
        end else if (m_active) begin
            if (!m_early && m_p < 0) begin
                int er;
                int e;
                er = n - 1;
                e  = er - int'(SS);
                if (er >= m_w && er < m_w + int'(TO) && e >= 1 && e < MaxCyc &&
                    led_hist[e] && !led_hist[e-1]) begin
                    m_rise = er;
                    m_p    = er + m_delay + 1;
                end else if (n == m_w + int'(TO)) begin
                    m_active = 1'b0;
                    m_to     = 1'b1;
                end
            end
            if (m_p >= 0 && n == m_p) begin
                m_resp = m_early ? 0 : ((m_delay + 1 > RespMax) ? RespMax : m_delay + 1);
            end
            if (m_p >= 0 && n == m_p + int'(PC) + 1) m_active = 1'b0;
        end else if (start && en) begin
            m_active = 1'b1;
            m_t0     = n;
            m_w      = n + int'(PC);
            m_early  = early;
            m_delay  = int'(delay_cfg);
            m_rise   = -1;
            m_resp   = 0;
            m_p      = early ? m_w + m_delay + 1 : -1;
        end
    endtask

    function automatic int exp_state(input int n);
        if (!m_active) return 0;
        if (n < m_w) return 1;
        if (m_p < 0 || n < m_p) return (m_early || m_rise < 0 || n <= m_rise) ? 2 : 3;
        if (n < m_p + int'(PC)) return 4;
        return 5;
    endfunction

    initial begin
        forever begin
            int st;
            @(posedge clk);
            cyc++;
            model_step(cyc);
            #1;
            st = exp_state(cyc);
            chk("state",    int'(state),    st);
            chk("user_btn", int'(user_btn), (st == 1 || st == 4) ? 1 : 0);
            chk("busy",     int'(busy),     (st != 0) ? 1 : 0);
            chk("done",     int'(done),     (m_active && m_p >= 0 && cyc == m_p + int'(PC)) ? 1 : 0);
            chk("timeout",  int'(timeout),  m_to ? 1 : 0);
            chk("resp_cnt", int'(resp_cnt), m_resp);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish before 100000 cycles");
        $fatal(1, "watchdog expired");
    end

    function automatic bit cond(input int which);
        case (which)
            WBtnHi:  return user_btn;
            WBtnLo:  return !user_btn;
            WDone:   return done;
            WTo:     return timeout;
            WDelay:  return state == 3'd3;
            WResp:   return state == 3'd4;
            default: return !busy;
        endcase
    endfunction

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse_start(input bit e, input int d);
        early     = e;
        delay_cfg = DW'(d);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_for(input int which, input int budget, input string name,
                            output int at_o);
        at_o = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cond(which)) begin
                at_o = cyc;
                break;
            end
        end
        if (at_o < 0) begin
            total++;
            bad++;
            $display("FAIL wait_%s: got no event, want one within %0d cycles", name, budget);
        end
    endtask

    initial begin
        int s, ep, l, b, w, t, d;
        int n_len;
        bit e_r;

        // Reset held while inputs toggle.
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = ~start;
            led   = ~led;
            chk("rst_btn",   int'(user_btn), 0);
            chk("rst_busy",  int'(busy), 0);
            chk("rst_state", int'(state), 0);
        end
        start = 1'b0;
        led   = 1'b0;
        cycles(4);
        areset_n = 1'b1;
        cycles(5);
        chk("post_rst_state", int'(state), 0);
        chk("post_rst_busy",  int'(busy), 0);

        // Normal trial, delay 10, led 50 cycles after start.
        pulse_start(1'b0, 10);
        s = cyc;
        wait_for(WBtnLo, 10, "sp_end", ep);
        chk("start_press_len", ep - s, 2);
        cycles(48);
        led = 1'b1;
        l = cyc + 1;
        wait_for(WBtnHi, 40, "resp10", b);
        chk("latency_d10", b - l, int'(SS) + 10 + 1);
        wait_for(WDone, 10, "done10", d);
        chk("resp_cnt_d10", int'(resp_cnt), 11);
        cycles(1);
        chk("done_once", int'(done), 0);
        chk("busy_after_done", int'(busy), 0);
        led = 1'b0;
        cycles(5);

        // Delay 0, then led already high at start.
        pulse_start(1'b0, 0);
        wait_for(WBtnLo, 10, "sp_end0", ep);
        cycles(5);
        led = 1'b1;
        l = cyc + 1;
        wait_for(WBtnHi, 20, "resp0", b);
        chk("latency_d0", b - l, int'(SS) + 1);
        wait_for(WDone, 10, "done0", d);
        chk("resp_cnt_d0", int'(resp_cnt), 1);
        cycles(3);
        pulse_start(1'b0, 0);
        wait_for(WBtnLo, 10, "sp_end0b", ep);
        cycles(20);
        chk("led_high_waits", int'(state), 2);
        chk("led_high_no_btn", int'(user_btn), 0);
        led = 1'b0;
        cycles(4);
        led = 1'b1;
        l = cyc + 1;
        wait_for(WBtnHi, 20, "resp0b", b);
        chk("latency_fresh_rise", b - l, int'(SS) + 1);
        wait_for(WDone, 10, "done0b", d);
        led = 1'b0;
        cycles(5);

        // Early mode with led held low.
        for (int k = 0; k < 2; k++) begin
            int dl;
            dl = (k == 0) ? 5 : 0;
            pulse_start(1'b1, dl);
            wait_for(WBtnLo, 10, "sp_end_early", w);
            wait_for(WBtnHi, 20, "resp_early", b);
            chk("early_latency", b - w, dl + 1);
            wait_for(WDone, 10, "done_early", d);
            chk("early_resp_cnt", int'(resp_cnt), 0);
            cycles(3);
        end

        // Timeout with led never rising.
        pulse_start(1'b0, 7);
        wait_for(WBtnLo, 10, "sp_end_to", w);
        wait_for(WTo, int'(TO) + 20, "timeout", t);
        chk("timeout_at", t - w, int'(TO));
        chk("timeout_state", int'(state), 0);
        chk("timeout_busy", int'(busy), 0);
        cycles(1);
        chk("timeout_single", int'(timeout), 0);
        cycles(3);

        // en low mid-DELAY.
        pulse_start(1'b0, 15);
        wait_for(WBtnLo, 10, "sp_end_en", ep);
        cycles(3);
        led = 1'b1;
        wait_for(WDelay, 10, "delay_en", d);
        en = 1'b0;
        cycles(1);
        chk("en_abort_state", int'(state), 0);
        chk("en_abort_btn", int'(user_btn), 0);
        chk("en_abort_resp", int'(resp_cnt), 0);
        en = 1'b1;
        cycles(20);
        led = 1'b0;
        cycles(4);

        // Asynchronous reset in RESP_PRESS, led falling during DELAY first.
        pulse_start(1'b0, 3);
        wait_for(WBtnLo, 10, "sp_end_rst", ep);
        cycles(2);
        led = 1'b1;
        wait_for(WDelay, 10, "delay_rst", d);
        led = 1'b0;
        wait_for(WResp, 10, "resp_rst", d);
        chk("resp_cnt_before_rst", int'(resp_cnt), 4);
        areset_n = 1'b0;
        #1;
        chk("async_rst_btn", int'(user_btn), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_state", int'(state), 0);
        cycles(3);
        areset_n = 1'b1;
        cycles(3);

        // Second start while busy is ignored.
        pulse_start(1'b0, 10);
        wait_for(WBtnLo, 10, "sp_end_busy", ep);
        cycles(3);
        pulse_start(1'b1, 3);
        cycles(10);
        led = 1'b1;
        l = cyc + 1;
        wait_for(WBtnHi, 40, "resp_busy", b);
        chk("busy_start_latency", b - l, int'(SS) + 10 + 1);
        wait_for(WDone, 10, "done_busy", d);
        chk("busy_start_resp", int'(resp_cnt), 11);
        led = 1'b0;
        cycles(5);

        // Randomised trials with led noise, stray starts and en glitches.
        for (int tr = 0; tr < 40; tr++) begin
            e_r = ($urandom_range(0, 3) == 0);
            pulse_start(e_r, int'($urandom_range(0, 25)));
            n_len = int'($urandom_range(5, 130));
            for (int i = 0; i < n_len; i++) begin
                @(negedge clk);
                if ($urandom_range(0, 9) == 0) led = ~led;
                start     = ($urandom_range(0, 15) == 0);
                early     = ($urandom_range(0, 3) == 0);
                delay_cfg = DW'($urandom_range(0, 25));
                en        = ($urandom_range(0, 149) != 0);
            end
            start = 1'b0;
            en    = 1'b1;
            wait_for(WIdle, 300, "idle_rand", d);
            led = 1'b0;
            cycles(4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reaction_responder.md
Name: reaction_responder

Overview:
- Automated "player" for the reaction timer: generates the start press, watches `led`, and presses `user_btn` a programmable number of cycles after `led` rises.
- Sits opposite the reaction timer on the `user_btn`/`led` interface, in benches and in on-board self-test.
- Reports the press latency it produced, so the measured `reaction` value can be checked against it.
- Also supports false-start generation, where it presses before `led`.

Parameters:
- DELAY_W, 14: width of `delay_cfg`, `resp_cnt` and the internal counters.
- PRESS_CYCLES, 2: cycles `user_btn` is held high per press (≥1).
- SYNC_STAGES, 2: flip-flop stages on the `led` input (≥2).
- TIMEOUT, 16383: maximum cycles spent in WAIT_LED before abort (< 2^DELAY_W).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-low reset.
- en  in  1  enable; low forces IDLE.
- start  in  1  one-cycle request to run one trial.
- early  in  1  false-start mode, sampled on `start`.
- delay_cfg  in  DELAY_W  response delay in cycles, sampled on `start`.
- led  in  1  stimulus from the reaction timer; asynchronous.
- user_btn  out  1  registered button drive to the reaction timer.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a trial completes with a response press.
- timeout  out  1  one-cycle pulse when WAIT_LED expires.
- resp_cnt  out  DELAY_W  cycles from the synced `led` rise to the `user_btn` rise; held until the next `start`.
- state  out  3  current FSM encoding, for debug.

Behaviour:
- Reset (`areset`=0): all outputs are 0 and FSM = IDLE, immediately and asynchronously. This includes the middle of a press: `user_btn` drops without waiting for a clock.
- `led` passes through SYNC_STAGES flops to give `led_s`. `led_rise` = `led_s` & ~`led_s_d`, registered.
- FSM encoding: IDLE=0, START_PRESS=1, WAIT_LED=2, DELAY=3, RESP_PRESS=4, FINISH=5.
- IDLE:
  - Taken when `start`&`en`.
  - Latches `delay_cfg` and `early`; clears `resp_cnt`.
  - Goes to START_PRESS.
- START_PRESS:
  - `user_btn`=1 for exactly PRESS_CYCLES cycles, then WAIT_LED with the counter cleared.
- WAIT_LED:
  - Normal mode:
    - A `led_rise` goes to DELAY with the counter at 0.
    - `led` already high on entry does not count; a fresh rising edge is required.
    - If the counter reaches TIMEOUT: `timeout` pulse, go to IDLE, no press.
  - Early mode:
    - `led` is ignored.
    - After the latched delay cycles, go to RESP_PRESS.
    - A delay of 0 presses on the next cycle.
- DELAY:
  - Counts up to the latched delay.
  - `user_btn` rises on the posedge exactly delay+1 cycles after the cycle in which `led_rise` was high.
  - A delay of 0 gives a 1-cycle response.
- RESP_PRESS:
  - `user_btn`=1 for PRESS_CYCLES cycles.
  - `resp_cnt` is captured on the first cycle: delay+1 in normal mode, 0 in early mode.
- FINISH:
  - `done`=1 for one cycle, then IDLE.
- `start` while `busy` is ignored; no queueing.
- `en` low in any state goes to IDLE on the next posedge:
  - `user_btn`=0 from that edge.
  - No `done` or `timeout` pulse.
  - `resp_cnt` keeps its last value.
- `led` falling during DELAY or RESP_PRESS has no effect; the press completes.
- Counters saturate and never wrap. The latched delay ≤ 2^DELAY_W−1 guarantees no overflow in DELAY.
- `done` and `timeout` are mutually exclusive and never occur in the same trial.

Decomposition:
- Shared package `reaction_pkg`:
  - FSM state encoding typedef (3-bit).
  - DELAY_W default 14, matching the reaction timer's 14-bit `reaction` width.
  - Default PRESS_CYCLES.
- One sub-module: `sync_edge`, the SYNC_STAGES synchroniser plus registered rising-edge detect. The reaction timer's button input reuses it.
- FSM, counters and `user_btn` register stay in the top module.

Test Plan:
- Reset held, toggle `start`/`led` → `user_btn`, `busy`, `done`, `timeout` all 0, `state`=0. Release reset → still idle.
- `start` with `delay_cfg`=10, `led` raised 50 cycles later → start press of 2 cycles. Then `user_btn` rises 10+1 cycles after `led_rise`, `resp_cnt`=11, `done` pulse once, `busy` drops the cycle after `done`.
- `delay_cfg`=0 → response press 1 cycle after `led_rise`, `resp_cnt`=1. With `led` already high at `start` → no response until `led` falls and rises again.
- `early`=1, `delay_cfg`=5, `led` held low → `user_btn` rises 6 cycles after the start press ends, `resp_cnt`=0, `done` pulses.
- Normal mode, `led` never rises, TIMEOUT=100 → `timeout` single pulse at WAIT_LED cycle 100, no response press, state=0.
- Mid-DELAY: `en` low → IDLE next edge with no `done`. Repeat with `areset` low in RESP_PRESS → `user_btn`=0 without a clock edge. A second `start` while `busy` → ignored, and the trial completes unchanged.
